// File: rtl/lsu_sram_ctrl.sv
// Load/store sequencer between a single-cycle RV32I core and a handshaked word SRAM.
// Builds byte-masked requests, stalls the core until ack, and formats load results.
module lsu_sram_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_rden,
  input  logic              i_mem_wren,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_st_data,
  output logic              o_stall,
  output logic [31:0]       o_ld_data,
  output logic              o_ld_vld,
  output logic              o_err,
  output logic              o_sram_req,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [3:0]        o_sram_bmask,
  output logic [31:0]       o_sram_wdata,
  input  logic              i_sram_ack,
  input  logic [31:0]       i_sram_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         bmask_q, bmask_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        ld_data_q, ld_data_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         lo_q, lo_d;
  logic               to_q, to_d;

  // Request decode: load wins when both enables are high
  logic        req_in, is_ld, f3_legal, aligned;
  logic [3:0]  mask_in;
  logic [31:0] wdata_in;
  logic        unused_addr_hi;

  assign req_in = i_mem_rden | i_mem_wren;
  assign is_ld  = i_mem_rden;
  assign f3_legal = is_ld ? ((i_funct3[1:0] != 2'b11) && !(i_funct3[2] && i_funct3[1]))
                          : (!i_funct3[2] && (i_funct3[1:0] != 2'b11));
  assign aligned = (i_funct3[1:0] == 2'b01) ? !i_addr[0] :
                   (i_funct3[1:0] == 2'b10) ? (i_addr[1:0] == 2'b00) : 1'b1;
  assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

  always_comb begin
    case (i_funct3[1:0])
      2'b00:   begin mask_in = 4'b0001 << i_addr[1:0];           wdata_in = {4{i_st_data[7:0]}};  end
      2'b01:   begin mask_in = i_addr[1] ? 4'b1100 : 4'b0011;    wdata_in = {2{i_st_data[15:0]}}; end
      default: begin mask_in = 4'b1111;                          wdata_in = i_st_data;            end
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
    logic [31:0] lane;
    lane = d >> {lo, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{24{lane[7]}}, lane[7:0]};
      3'b001:  fmt_load = {{16{lane[15]}}, lane[15:0]};
      3'b100:  fmt_load = {24'd0, lane[7:0]};
      3'b101:  fmt_load = {16'd0, lane[15:0]};
      default: fmt_load = lane;
    endcase
  endfunction

  // Next-state and core-facing outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    bmask_d   = bmask_q;
    wdata_d   = wdata_q;
    ld_data_d = ld_data_q;
    f3_d      = f3_q;
    lo_d      = lo_q;
    to_d      = to_q;
    o_stall   = 1'b0;
    o_err     = 1'b0;
    o_ld_vld  = 1'b0;
    o_ld_data = ld_data_q;
    case (state_q)
      IDLE: begin
        if (req_in && !i_reset) begin
          if (f3_legal && aligned) begin
            o_stall = 1'b1;
            state_d = ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = !is_ld;
            addr_d  = i_addr[ADDR_W+1:2];
            bmask_d = mask_in;
            wdata_d = is_ld ? 32'd0 : wdata_in;
            f3_d    = i_funct3;
            lo_d    = i_addr[1:0];
            to_d    = 1'b0;
          end else begin
            o_err = 1'b1;
            if (is_ld) begin
              o_ld_vld  = 1'b1;
              o_ld_data = 32'd0;
              ld_data_d = 32'd0;
            end
          end
        end
      end
      ACCESS: begin
        o_stall = 1'b1;
        if (i_sram_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) ld_data_d = fmt_load(f3_q, lo_q, i_sram_rdata);
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          to_d    = 1'b1;
          state_d = DONE;
          if (!we_q) ld_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        o_ld_vld = !we_q && !i_reset;
        o_err    = to_q && !i_reset;
        to_d     = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      bmask_q   <= '0;
      wdata_q   <= '0;
      ld_data_q <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      bmask_q   <= bmask_d;
      wdata_q   <= wdata_d;
      ld_data_q <= ld_data_d;
      f3_q      <= f3_d;
      lo_q      <= lo_d;
      to_q      <= to_d;
    end
  end

  assign o_sram_req   = req_q;
  assign o_sram_we    = we_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_bmask = bmask_q;
  assign o_sram_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Directed bench for lsu_sram_ctrl: per-cycle expectations from a transaction-level model.
module tb_lsu_sram_ctrl;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rden = 1'b0, wren = 1'b0;
  logic [2:0]        funct3 = '0;
  logic [31:0]       addr = '0, st_data = '0;
  logic              stall, ld_vld, err, sram_req, sram_we;
  logic [31:0]       ld_data, sram_wdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [3:0]        sram_bmask;
  logic              ack = 1'b0;
  logic [31:0]       rdata = '0;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, set by the stimulus
  bit          chk_en = 1'b0;
  logic        exp_stall, exp_err, exp_vld, exp_req, exp_we;
  logic [31:0] exp_ld, exp_addr, exp_wd;
  logic [3:0]  exp_mask;
  logic [31:0] hold = '0;

  always #5 clk = ~clk;

  lsu_sram_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_mem_rden(rden), .i_mem_wren(wren), .i_funct3(funct3),
    .i_addr(addr), .i_st_data(st_data),
    .o_stall(stall), .o_ld_data(ld_data), .o_ld_vld(ld_vld), .o_err(err),
    .o_sram_req(sram_req), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
    .o_sram_bmask(sram_bmask), .o_sram_wdata(sram_wdata),
    .i_sram_ack(ack), .i_sram_rdata(rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit model_legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    bit ok_f3, ok_al;
    ok_f3 = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    ok_al = (f3[1:0] == 2'd1) ? (a % 2 == 0) : (f3[1:0] == 2'd2) ? (a % 4 == 0) : 1'b1;
    return ok_f3 && ok_al;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << nbytes(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (nbytes(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (nbytes(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n;
    logic [31:0] v, m;
    n = 8 * nbytes(f3);
    v = rd >> ((a % 4) * 8);
    if (n == 32) return v;
    m = (32'd1 << n) - 32'd1;
    v = v & m;
    if (!f3[2] && v[n-1]) v = v | ~m;
    return v;
  endfunction

  // Per-cycle comparison against the expectations
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("err", 32'(err), 32'(exp_err));
      chk("ld_vld", 32'(ld_vld), 32'(exp_vld));
      chk("ld_data", ld_data, exp_ld);
      chk("sram_req", 32'(sram_req), 32'(exp_req));
      if (exp_req) begin
        chk("sram_addr", 32'(sram_addr), exp_addr);
        chk("sram_we", 32'(sram_we), 32'(exp_we));
        chk("sram_bmask", 32'(sram_bmask), 32'(exp_mask));
        if (exp_we) chk("sram_wdata", sram_wdata, exp_wd);
      end
    end
  end

  task automatic set_quiet();
    exp_stall = 1'b0; exp_err = 1'b0; exp_vld = 1'b0; exp_req = 1'b0; exp_ld = hold;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rden = 1'b0; wren = 1'b0; ack = 1'b0;
      set_quiet();
    end
  endtask

  // One instruction from acceptance through DONE; waits >= TIMEOUT means no ack
  task automatic access(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int waits, input logic [31:0] rd,
                        input bit use_lit, input logic [31:0] lit_ld, input logic [31:0] lit_wd,
                        input logic [3:0] lit_mask, input logic [31:0] lit_addr);
    bit legal, tmo;
    int ncyc;
    legal = model_legal(ld, f3, a);
    @(posedge clk); #1;
    rden = ld; wren = st; funct3 = f3; addr = a; st_data = sd; ack = 1'b0;
    rdata = 32'h5A5A_A5A5;
    if (!legal) begin
      exp_stall = 1'b0; exp_err = 1'b1; exp_vld = ld; exp_req = 1'b0;
      if (ld) hold = 32'd0;
      exp_ld = hold;
      if (use_lit) begin
        @(negedge clk);
        chk("lit_err", 32'(err), 32'd1);
        if (ld) chk("lit_err_ld", ld_data, lit_ld);
      end
      return;
    end
    exp_stall = 1'b1; exp_err = 1'b0; exp_vld = 1'b0; exp_req = 1'b0; exp_ld = hold;
    exp_addr = 32'(a[ADDR_W+1:2]);
    exp_we   = !ld;
    exp_mask = model_mask(f3, a);
    exp_wd   = model_wdata(f3, sd);
    tmo  = (waits >= int'(TIMEOUT));
    ncyc = tmo ? int'(TIMEOUT) : waits + 1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      exp_req = 1'b1; exp_stall = 1'b1;
      ack   = (!tmo && k == waits);
      rdata = ack ? rd : 32'h5A5A_A5A5;
      if (use_lit && k == 0) begin
        @(negedge clk);
        chk("lit_addr", 32'(sram_addr), lit_addr);
        chk("lit_bmask", 32'(sram_bmask), 32'(lit_mask));
        if (st && !ld) chk("lit_wdata", sram_wdata, lit_wd);
      end
    end
    @(posedge clk); #1;
    ack = 1'b0; rdata = 32'h5A5A_A5A5;
    exp_req = 1'b0; exp_stall = 1'b0; exp_err = tmo; exp_vld = ld;
    if (ld) hold = tmo ? 32'd0 : model_load(f3, a, rd);
    exp_ld = hold;
    if (use_lit && ld) begin
      @(negedge clk);
      chk("lit_ld_data", ld_data, lit_ld);
    end
  endtask

  initial begin
    set_quiet();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    idle(1);
    @(negedge clk);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_bmask", 32'(sram_bmask), 32'd0);
    chk("rst_wdata", sram_wdata, 32'd0);

    // SW 0xDEADBEEF to 0x100, zero-wait ack
    access(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 32'h0, 1, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h40);
    idle(1);
    // LB / LBU from 0x103
    access(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FF7F, 1, 32'hFFFF_FF80, 32'h0, 4'b1000, 32'h40);
    idle(1);
    access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_FF7F, 1, 32'h0000_0080, 32'h0, 4'b1000, 32'h40);
    idle(1);
    // SH to 0x102, then misaligned LHU
    access(0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 0, 32'h0, 1, 32'h0, 32'hABCD_ABCD, 4'b1100, 32'h40);
    idle(1);
    access(1, 0, 3'b101, 32'h101, 32'h0, 0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
    idle(2);
    // LH sign extension, SB lane 3, load wins over store
    access(1, 0, 3'b001, 32'h202, 32'h0, 2, 32'h8001_0000, 1, 32'hFFFF_8001, 32'h0, 4'b1100, 32'h80);
    idle(1);
    access(0, 1, 3'b000, 32'h0FF, 32'h0000_00C3, 0, 32'h0, 1, 32'h0, 32'hC3C3_C3C3, 4'b1000, 32'h3F);
    idle(1);
    access(1, 1, 3'b010, 32'h008, 32'hFFFF_FFFF, 0, 32'h1357_9BDF, 0, 32'h0, 32'h0, 4'b0, 32'h0);
    idle(1);
    // Illegal store funct3, misaligned SW
    access(0, 1, 3'b100, 32'h010, 32'h0, 0, 32'h0, 1, 32'h0, 32'h0, 4'b0, 32'h0);
    idle(1);
    access(0, 1, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1, 32'h0, 32'h0, 4'b0, 32'h0);
    idle(1);
    // Timeout on a load, then a legal load with 3 wait cycles
    access(1, 0, 3'b100, 32'h003, 32'h0, 0, 32'h0000_7700, 0, 32'h0, 32'h0, 4'b0, 32'h0);
    idle(1);
    access(1, 0, 3'b010, 32'h200, 32'h0, 1000, 32'h0, 1, 32'h0, 32'h0, 4'b1111, 32'h80);
    idle(1);
    access(1, 0, 3'b010, 32'h204, 32'h0, 3, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'h81);
    idle(1);

    // Reset two cycles into ACCESS, then a stray ack with no request
    @(posedge clk); #1;
    rden = 1'b1; wren = 1'b0; funct3 = 3'b010; addr = 32'h300;
    exp_stall = 1'b1; exp_err = 1'b0; exp_vld = 1'b0; exp_req = 1'b0; exp_ld = hold;
    exp_addr = 32'hC0; exp_we = 1'b0; exp_mask = 4'b1111;
    @(posedge clk); #1;
    exp_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; chk_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; chk_en = 1'b1;
    rden = 1'b0;
    hold = 32'd0;
    set_quiet();
    @(negedge clk);
    chk("rst_mid_addr", 32'(sram_addr), 32'd0);
    chk("rst_mid_bmask", 32'(sram_bmask), 32'd0);
    @(posedge clk); #1;
    ack = 1'b1; rdata = 32'h1234_5678;
    set_quiet();
    idle(2);

    // Back-to-back LW then SW with zero-wait ack
    access(1, 0, 3'b010, 32'h010, 32'h0, 0, 32'h0BAD_CAFE, 1, 32'h0BAD_CAFE, 32'h0, 4'b1111, 32'h4);
    access(0, 1, 3'b010, 32'h014, 32'h7654_3210, 0, 32'h0, 1, 32'h0, 32'h7654_3210, 4'b1111, 32'h5);
    idle(3);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
